// File: rtl/regfile_multiport_if.sv
// ----------------------------------------------------------------------------
// regfile_multiport_if
//
// Purpose : bundles the read and write port signals of regfile_multiport so
//           the register file and its users connect through one port.
//
// Signals :
//   raddr_i     NR_READ_PORTS x ADDR_WIDTH   read addresses
//   rdata_o     NR_READ_PORTS x DATA_WIDTH   read data (combinational)
//   waddr_i     NR_WRITE_PORTS x ADDR_WIDTH  write addresses
//   wdata_i     NR_WRITE_PORTS x DATA_WIDTH  write data
//   we_i        NR_WRITE_PORTS               per-port write enable
//   collision_o 1                            registered same-word write flag
//
// Handshake: there is none. Every enabled write port is accepted on every
// rising clock edge, and read data is valid whenever the address is stable.
// Nothing back-pressures the writer.
//
// Modports:
//   master : the register file user (drives addresses/data/enables)
//   slave  : the register file itself
// ----------------------------------------------------------------------------
interface regfile_multiport_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NR_READ_PORTS  = 2,
    parameter int NR_WRITE_PORTS = 2
);
    logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
    logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NR_WRITE_PORTS-1:0]                 we_i;
    logic                                      collision_o;

    modport master (
        output raddr_i,
        output waddr_i,
        output wdata_i,
        output we_i,
        input  rdata_o,
        input  collision_o
    );

    modport slave (
        input  raddr_i,
        input  waddr_i,
        input  wdata_i,
        input  we_i,
        output rdata_o,
        output collision_o
    );
endinterface

// File: rtl/regfile_multiport.sv
// ----------------------------------------------------------------------------
// regfile_multiport
//
// Purpose : flip-flop based multi-port integer register file. Each write port
//           is decoded one-hot per word; when several enabled ports hit the
//           same word in one cycle the highest-index port wins and a
//           registered collision flag is raised for the following cycle.
//           Optional write-to-read bypass returns same-cycle write data.
//
// Ports   :
//   clk_i   in   clock, all state updates on the rising edge
//   rst_i   in   synchronous active-high reset; clears storage and the
//                collision flag, and discards writes of that cycle
//   rf_bus  slave modport of regfile_multiport_if (read/write ports and
//                collision_o)
//
// Parameters:
//   DATA_WIDTH, ADDR_WIDTH (NUM_WORDS = 2**ADDR_WIDTH), NR_READ_PORTS,
//   NR_WRITE_PORTS, ZERO_REG_ZERO (word 0 hardwired to zero),
//   BYPASS_EN (reads see same-cycle write data).
// ----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NR_READ_PORTS  = 2,
    parameter int NR_WRITE_PORTS = 2,
    parameter bit ZERO_REG_ZERO  = 1'b1,
    parameter bit BYPASS_EN      = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    regfile_multiport_if.slave  rf_bus
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    // Lowest word that has real storage.
    localparam int FIRST_WR  = ZERO_REG_ZERO ? 1 : 0;

    logic [NR_WRITE_PORTS-1:0][NUM_WORDS-1:0] w_onehot;
    logic [NUM_WORDS-1:0]                     w_word_we;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]     w_word_wdata;
    logic [NUM_WORDS-1:0]                     w_word_coll;
    logic [DATA_WIDTH-1:0]                    w_mem [NUM_WORDS];
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] w_rdata;
    logic                                     r_collision;

    // One-hot write decode per port. Word 0 is left out entirely when it is
    // hardwired, so writes to it neither store nor count as collisions.
    always_comb begin
        w_onehot = '0;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            for (int j = FIRST_WR; j < NUM_WORDS; j++) begin
                w_onehot[p][j] = rf_bus.we_i[p] &&
                                 (rf_bus.waddr_i[p] == ADDR_WIDTH'(j));
            end
        end
    end

    // Per-word resolution. Ports are scanned in ascending order so a later
    // (higher-index) hit overwrites the selected data: highest port wins.
    // A hit on a word that already had one marks that word as colliding.
    always_comb begin
        w_word_we    = '0;
        w_word_wdata = '0;
        w_word_coll  = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (w_onehot[p][j]) begin
                    if (w_word_we[j]) begin
                        w_word_coll[j] = 1'b1;
                    end
                    w_word_we[j]    = 1'b1;
                    w_word_wdata[j] = rf_bus.wdata_i[p];
                end
            end
        end
    end

    // Storage. A hardwired word 0 gets no flops at all.
    for (genvar j = 0; j < NUM_WORDS; j++) begin : g_word
        if (ZERO_REG_ZERO && (j == 0)) begin : g_zero
            logic w_unused_zero;
            assign w_unused_zero = ^{w_word_we[j], w_word_wdata[j], w_word_coll[j]};
            assign w_mem[j]      = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] r_word;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_word <= '0;
                end else if (w_word_we[j]) begin
                    r_word <= w_word_wdata[j];
                end
            end
            assign w_mem[j] = r_word;
        end
    end

    // Read ports. The bypass reuses the resolved per-word write data, so it
    // follows the same priority as storage, and word 0 (never enabled when
    // hardwired) still reads zero.
    always_comb begin
        w_rdata = '0;
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            w_rdata[r] = w_mem[rf_bus.raddr_i[r]];
            if (BYPASS_EN && w_word_we[rf_bus.raddr_i[r]]) begin
                w_rdata[r] = w_word_wdata[rf_bus.raddr_i[r]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= |w_word_coll;
        end
    end

    assign rf_bus.rdata_o     = w_rdata;
    assign rf_bus.collision_o = r_collision;

endmodule

// File: tb/tb_regfile_multiport.sv
// ----------------------------------------------------------------------------
// tb_regfile_multiport
//
// Two register files driven by identical stimulus:
//   dut_a : ZERO_REG_ZERO=1, BYPASS_EN=0
//   dut_b : ZERO_REG_ZERO=0, BYPASS_EN=1
// Directed cases cover reset, parallel writes, collisions, the zero register
// and bypass; a randomized sweep follows. Expected values come from a
// behavioural array model of each configuration.
// ----------------------------------------------------------------------------
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 3;
    localparam int NWORDS = 2 ** AW;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ stimulus
    logic [NR-1:0][AW-1:0] raddr = '0;
    logic [NW-1:0][AW-1:0] waddr = '0;
    logic [NW-1:0][DW-1:0] wdata = '0;
    logic [NW-1:0]         we    = '0;

    regfile_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                           .NR_READ_PORTS(NR), .NR_WRITE_PORTS(NW)) if_a ();
    regfile_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                           .NR_READ_PORTS(NR), .NR_WRITE_PORTS(NW)) if_b ();

    assign if_a.raddr_i = raddr;
    assign if_a.waddr_i = waddr;
    assign if_a.wdata_i = wdata;
    assign if_a.we_i    = we;
    assign if_b.raddr_i = raddr;
    assign if_b.waddr_i = waddr;
    assign if_b.wdata_i = wdata;
    assign if_b.we_i    = we;

    regfile_multiport #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NR),
        .NR_WRITE_PORTS(NW), .ZERO_REG_ZERO(1'b1), .BYPASS_EN(1'b0)
    ) dut_a (
        .clk_i  (clk),
        .rst_i  (rst),
        .rf_bus (if_a.slave)
    );

    regfile_multiport #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NR),
        .NR_WRITE_PORTS(NW), .ZERO_REG_ZERO(1'b0), .BYPASS_EN(1'b1)
    ) dut_b (
        .clk_i  (clk),
        .rst_i  (rst),
        .rf_bus (if_b.slave)
    );

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // Index 0 models dut_a, index 1 models dut_b.
    logic [DW-1:0] mem_m  [2][NWORDS];
    logic          coll_m [2];

    function automatic bit zero_reg(input int c);
        return (c == 0);
    endfunction

    function automatic bit bypass(input int c);
        return (c == 1);
    endfunction

    // Expected combinational read for the inputs currently applied.
    function automatic logic [DW-1:0] exp_read(input int c, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (zero_reg(c) && a == 0) return '0;
        v = mem_m[c][a];
        if (bypass(c)) begin
            for (int p = 0; p < NW; p++) begin
                if (we[p] && waddr[p] == a) v = wdata[p];
            end
        end
        return v;
    endfunction

    // Apply one rising edge to the model: ports written in order, so the
    // highest-numbered port is the last one standing on a shared word.
    task automatic model_edge();
        int hits [NWORDS];
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int j = 0; j < NWORDS; j++) mem_m[c][j] = '0;
                coll_m[c] = 1'b0;
            end else begin
                for (int j = 0; j < NWORDS; j++) hits[j] = 0;
                for (int p = 0; p < NW; p++) begin
                    if (we[p] && !(zero_reg(c) && waddr[p] == 0)) begin
                        hits[waddr[p]]++;
                        mem_m[c][waddr[p]] = wdata[p];
                    end
                end
                coll_m[c] = 1'b0;
                for (int j = 0; j < NWORDS; j++) begin
                    if (hits[j] >= 2) coll_m[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_against_model();
        for (int r = 0; r < NR; r++) begin
            check($sformatf("a_rd%0d", r), if_a.rdata_o[r], exp_read(0, raddr[r]));
            check($sformatf("b_rd%0d", r), if_b.rdata_o[r], exp_read(1, raddr[r]));
        end
        check("a_coll", {31'b0, if_a.collision_o}, {31'b0, coll_m[0]});
        check("b_coll", {31'b0, if_b.collision_o}, {31'b0, coll_m[1]});
    endtask

    // ------------------------------------------------------------ driver tasks
    // Inputs change 1 time unit after the rising edge; explicit checks run at
    // +2, model checks at +3, and the model follows the DUT at the next edge.
    task automatic cycle();
        #1;
        check_against_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we    = '0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        we[p]    = 1'b1;
        waddr[p] = AW'(a);
        wdata[p] = d;
    endtask

    task automatic rd(input int a0, input int a1);
        raddr[0] = AW'(a0);
        raddr[1] = AW'(a1);
    endtask

    // ------------------------------------------------------------ test sequence
    initial begin
        // Storage starts unknown, so the first reset edges are not compared.
        rst = 1'b1;
        idle();
        rd(0, 0);
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
        #1;
        check("reset_a_coll", {31'b0, if_a.collision_o}, 32'h0);
        check("reset_b_rd", if_b.rdata_o[0], 32'h0);
        cycle();

        // Reset dominates a same-cycle write.
        wr(0, 5, 32'hDEADBEEF);
        cycle();
        idle();
        rst = 1'b1;
        wr(0, 6, 32'h00001234);
        cycle();
        rst = 1'b0;
        idle();
        rd(5, 6);
        #1;
        check("rst_a_r5", if_a.rdata_o[0], 32'h0);
        check("rst_a_r6", if_a.rdata_o[1], 32'h0);
        check("rst_b_r5", if_b.rdata_o[0], 32'h0);
        check("rst_b_r6", if_b.rdata_o[1], 32'h0);
        check("rst_a_coll", {31'b0, if_a.collision_o}, 32'h0);
        cycle();

        // Parallel writes to distinct words.
        wr(0, 3, 32'h11111111);
        wr(1, 7, 32'h22222222);
        rd(3, 7);
        cycle();
        idle();
        #1;
        check("par_a_r3", if_a.rdata_o[0], 32'h11111111);
        check("par_a_r7", if_a.rdata_o[1], 32'h22222222);
        check("par_a_coll", {31'b0, if_a.collision_o}, 32'h0);
        cycle();

        // Same-word collision: port 1 wins, flag pulses for one cycle.
        wr(0, 9, 32'hAAAA0000);
        wr(1, 9, 32'h0000BBBB);
        rd(9, 9);
        cycle();
        idle();
        #1;
        check("col_a_r9", if_a.rdata_o[0], 32'h0000BBBB);
        check("col_b_r9", if_b.rdata_o[0], 32'h0000BBBB);
        check("col_a_flag", {31'b0, if_a.collision_o}, 32'h1);
        check("col_b_flag", {31'b0, if_b.collision_o}, 32'h1);
        cycle();
        #1;
        check("col_a_flag_end", {31'b0, if_a.collision_o}, 32'h0);
        cycle();

        // Three-way collision: port 2 wins.
        wr(0, 12, 32'h01010101);
        wr(1, 12, 32'h02020202);
        wr(2, 12, 32'h03030303);
        rd(12, 0);
        cycle();
        idle();
        #1;
        check("col3_a_r12", if_a.rdata_o[0], 32'h03030303);
        cycle();

        // Both ports write word 0.
        wr(0, 0, 32'hA5A5A5A5);
        wr(1, 0, 32'h5A5A5A5A);
        rd(0, 0);
        cycle();
        idle();
        #1;
        check("zero_a_r0", if_a.rdata_o[0], 32'h0);
        check("zero_a_coll", {31'b0, if_a.collision_o}, 32'h0);
        check("zero_b_r0", if_b.rdata_o[0], 32'h5A5A5A5A);
        check("zero_b_coll", {31'b0, if_b.collision_o}, 32'h1);
        cycle();

        // Bypass vs stored read of r4.
        wr(0, 4, 32'h00000005);
        cycle();
        idle();
        wr(1, 4, 32'h00000077);
        rd(4, 0);
        #1;
        check("byp_a_same", if_a.rdata_o[0], 32'h00000005);
        check("byp_b_same", if_b.rdata_o[0], 32'h00000077);
        cycle();
        idle();
        #1;
        check("byp_a_next", if_a.rdata_o[0], 32'h00000077);
        cycle();

        // Randomized sweep; narrow address ranges half the time to provoke
        // collisions, with an occasional reset.
        for (int i = 0; i < 10000; i++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            rst    = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NW; p++) begin
                we[p]    = ($urandom_range(0, 2) != 0);
                waddr[p] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NWORDS - 1));
                wdata[p] = $urandom;
            end
            for (int r = 0; r < NR; r++) begin
                raddr[r] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NWORDS - 1));
            end
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port, flip-flop based integer register file with one-hot write-address decoding per write port. It is the next generation of the team's latch-based register file decoder: depth, port counts and zero-register policy are generalised, and it adds same-cycle write-collision resolution, optional write-to-read bypass and a registered collision flag. It sits in the core's decode/writeback boundary: read ports feed operand fetch, write ports take writeback results.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; NUM_WORDS = 2**ADDR_WIDTH
- NR_READ_PORTS, 2, number of read ports (>=1)
- NR_WRITE_PORTS, 2, number of write ports (>=1)
- ZERO_REG_ZERO, 1, 1: register 0 is hardwired to zero; 0: register 0 is writable storage
- BYPASS_EN, 0, 1: read ports return same-cycle write data (write-through); 0: read returns stored value

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- raddr_i  in  NR_READ_PORTS x ADDR_WIDTH  read addresses
- rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data, combinational
- waddr_i  in  NR_WRITE_PORTS x ADDR_WIDTH  write addresses
- wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data
- we_i  in  NR_WRITE_PORTS  per-port write enable
- collision_o  out  1  registered; high the cycle after two or more enabled ports targeted the same writable address

## Operation
- Storage: NUM_WORDS x DATA_WIDTH flops. With ZERO_REG_ZERO=1, word 0 has no storage and reads as 0.
- Write decode: per port p, onehot[p][j] = we_i[p] && waddr_i[p]==j, for j in writable range (1..NUM_WORDS-1 if ZERO_REG_ZERO else 0..NUM_WORDS-1).
- Collision resolution: per word, highest-index enabled port hitting it wins; lower ports' data for that word dropped. Distinct addresses from different ports all write in the same cycle.
- Collision detect: collision_o <= 1 if any writable word has >=2 onehot bits set this cycle, else 0. Writes to word 0 when ZERO_REG_ZERO=1 never count as a collision.
- Read: rdata_o[r] = stored word raddr_i[r]. If BYPASS_EN=1 and some enabled port writes raddr_i[r] this cycle, rdata_o[r] = winning port's wdata_i (same priority as storage). Word 0 with ZERO_REG_ZERO=1 reads 0 regardless of bypass.
- Reset: when rst_i high at a rising edge, all storage words and collision_o cleared to 0; writes presented in that cycle are discarded (reset dominates).
- Out-of-range addresses impossible (full ADDR_WIDTH decode).

## Timing
- Write latency: data presented with we_i at edge N is readable (non-bypass) in cycle N+1.
- Bypass read latency: 0 cycles (combinational wdata_i -> rdata_o path); enabling BYPASS_EN adds this path to timing.
- Read latency: combinational from raddr_i and storage.
- collision_o: 1-cycle pulse per colliding cycle; back-to-back collisions keep it high continuously.
- Reset values: all words 0, collision_o 0; rdata_o therefore 0 for every address in the first cycle after reset (unless bypassed write present).
- Reset asserted mid-burst: writes at the reset edge are lost; first post-reset write lands at the next edge after rst_i deasserts.
- No handshake: write ports always accepted; no back-pressure.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_i one cycle with simultaneous write of 0x1234 to r6 -> r5 and r6 read 0x0, collision_o 0.
- Parallel writes: port0 r3=0x11111111, port1 r7=0x22222222 same cycle -> next cycle r3=0x11111111, r7=0x22222222, collision_o 0.
- Collision: port0 and port1 both write r9 (0xAAAA0000, 0x0000BBBB) -> r9=0x0000BBBB next cycle, collision_o=1 for exactly one cycle.
- Zero register (ZERO_REG_ZERO=1): both ports write r0 -> r0 reads 0, collision_o stays 0; with ZERO_REG_ZERO=0 same stimulus -> r0 = port1 data, collision_o=1.
- Bypass (BYPASS_EN=1): r4 holds 0x5; port1 writes r4=0x77 while read port0 addresses r4 -> rdata_o[0]=0x77 same cycle; with BYPASS_EN=0 -> 0x5 same cycle, 0x77 next cycle.
- Sweep: random addresses/enables on all ports for 10k cycles against a priority-ordered reference model; rdata_o and collision_o match every cycle.
